// File: rtl/fifo_ctrl_dp.sv
// First-word-fall-through FIFO controller driving an external dual-port RAM
// (port A write-only, port B read-only with 1-cycle registered read).
module fifo_ctrl_dp #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = ADDR_WIDTH + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    output logic                  full,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  empty,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [WIDTH-1:0]      ram_dina,
    output logic                  ram_ena,
    output logic                  ram_wra,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic [WIDTH-1:0]      ram_dinb,
    output logic                  ram_enb,
    output logic                  ram_wrb,
    input  logic [WIDTH-1:0]      ram_doutb
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  FULL_CNT  = CNT_WIDTH'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [CNT_WIDTH-1:0]  ram_cnt_reg;
    logic [CNT_WIDTH-1:0]  ram_cnt_next;
    logic                  inflight_reg;
    logic [1:0]            out_cnt_reg;
    logic [1:0]            out_cnt_next;
    logic [1:0]            out_cnt_popped;
    logic [WIDTH-1:0]      buf_reg  [2];
    logic [WIDTH-1:0]      buf_next [2];
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  push_fire;
    logic                  pop_fire;
    logic                  rd_issue;
    logic [2:0]            pending;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    assign full      = (ram_cnt_reg == FULL_CNT);
    assign empty     = (out_cnt_reg == 2'd0);
    // Gated by rst so the RAM sees no write while reset is held.
    assign push_fire = push & ~full & ~rst;
    assign pop_fire  = pop & ~empty;

    // Entries that will occupy the output buffer after this cycle's pop.
    assign pending  = {1'b0, out_cnt_reg} + {2'b00, inflight_reg} - {2'b00, pop_fire};
    assign rd_issue = (ram_cnt_reg != '0) & (pending < 3'd2);

    assign ram_cnt_next = ram_cnt_reg + CNT_WIDTH'(push_fire) - CNT_WIDTH'(rd_issue);

    always_comb begin
        out_cnt_popped = out_cnt_reg - {1'b0, pop_fire};
        buf_next[0]    = buf_reg[0];
        buf_next[1]    = buf_reg[1];
        if (pop_fire) begin
            buf_next[0] = buf_reg[1];
        end
        // Returning data lands behind whatever survives the pop.
        if (inflight_reg) begin
            buf_next[out_cnt_popped[0]] = ram_doutb;
        end
        out_cnt_next = out_cnt_popped + {1'b0, inflight_reg};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            ram_cnt_reg   <= '0;
            inflight_reg  <= 1'b0;
            out_cnt_reg   <= 2'd0;
            buf_reg[0]    <= '0;
            buf_reg[1]    <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (push_fire) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (rd_issue) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            ram_cnt_reg  <= ram_cnt_next;
            inflight_reg <= rd_issue;
            out_cnt_reg  <= out_cnt_next;
            buf_reg[0]   <= buf_next[0];
            buf_reg[1]   <= buf_next[1];
            if (push & full) begin
                overflow_reg <= 1'b1;
            end
            if (pop & empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign pop_data  = buf_reg[0];
    assign count     = ram_cnt_reg + CNT_WIDTH'(inflight_reg) + CNT_WIDTH'(out_cnt_reg);
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

    assign ram_addra = wr_ptr_reg;
    assign ram_dina  = push_data;
    assign ram_ena   = push_fire;
    assign ram_wra   = push_fire;
    assign ram_addrb = rd_ptr_reg;
    assign ram_enb   = rd_issue;
    assign ram_dinb  = '0;
    assign ram_wrb   = 1'b0;

endmodule

// File: tb/tb_fifo_ctrl_dp.sv
// Bench for fifo_ctrl_dp: RAM model, queue scoreboard, directed and random traffic.
module tb_fifo_ctrl_dp;
    localparam int WIDTH = 64;
    localparam int DEPTH = 5;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             full;
    logic             pop;
    logic [WIDTH-1:0] pop_data;
    logic             empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic [AW-1:0]    ram_addra;
    logic [WIDTH-1:0] ram_dina;
    logic             ram_ena;
    logic             ram_wra;
    logic [AW-1:0]    ram_addrb;
    logic [WIDTH-1:0] ram_dinb;
    logic             ram_enb;
    logic             ram_wrb;
    logic [WIDTH-1:0] ram_doutb = '0;

    fifo_ctrl_dp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .push(push), .push_data(push_data), .full(full),
        .pop(pop), .pop_data(pop_data), .empty(empty),
        .count(count), .overflow(overflow), .underflow(underflow),
        .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_ena(ram_ena), .ram_wra(ram_wra),
        .ram_addrb(ram_addrb), .ram_dinb(ram_dinb), .ram_enb(ram_enb), .ram_wrb(ram_wrb),
        .ram_doutb(ram_doutb)
    );

    always #5 clk = ~clk;

    // Dual-port RAM macro: port A write, port B registered read.
    logic [WIDTH-1:0] mem [8];
    always @(posedge clk) begin
        if (ram_ena && ram_wra) mem[ram_addra] <= ram_dina;
        if (ram_enb) ram_doutb <= mem[ram_addrb];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: the FIFO contents are a plain queue of accepted words.
    logic [63:0] model_q[$];
    int          wr_n, rd_n, pop_total;
    logic        ovf_m, udf_m;

    always @(negedge clk) begin
        if (rst) begin
            model_q.delete();
            wr_n = 0; rd_n = 0; pop_total = 0;
            ovf_m = 1'b0; udf_m = 1'b0;
        end else begin
            chk("count", 64'(count), 64'(model_q.size()));
            chk("overflow", 64'(overflow), 64'(ovf_m));
            chk("underflow", 64'(underflow), 64'(udf_m));
            if (model_q.size() == 0) chk("empty_when_none", 64'(empty), 64'(1));
            if (model_q.size() < DEPTH) chk("full_low", 64'(full), 64'(0));
            if (model_q.size() == DEPTH + 2) chk("full_at_cap", 64'(full), 64'(1));
            if (ram_ena && ram_enb) chk("rw_same_addr", 64'(ram_addra == ram_addrb), 64'(0));
            if (ram_enb) begin
                chk("ram_addrb", 64'(ram_addrb), 64'(rd_n % DEPTH));
                rd_n++;
            end
            if (push && full) ovf_m = 1'b1;
            if (push && !full) begin
                chk("ram_en_a", 64'({ram_ena, ram_wra}), 64'(3));
                chk("ram_addra", 64'(ram_addra), 64'(wr_n % DEPTH));
                chk("ram_dina", ram_dina, push_data);
                $display("push #%0d data=%h addr=%0d", wr_n, push_data, ram_addra);
                wr_n++;
                model_q.push_back(push_data);
            end else begin
                chk("ram_ena_idle", 64'(ram_ena), 64'(0));
            end
            if (pop && empty) udf_m = 1'b1;
            if (pop && !empty) begin
                if (model_q.size() == 0) begin
                    chk("pop_unexpected", 64'(1), 64'(0));
                end else begin
                    chk("pop_data", pop_data, model_q[0]);
                    $display("pop  #%0d data=%h", pop_total, pop_data);
                    void'(model_q.pop_front());
                end
                pop_total++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [63:0] w0, w1;
    int accepted, guard, sent;

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_pop_data", pop_data, 64'(0));
        chk("rst_ram_en", 64'({ram_ena, ram_wra, ram_enb}), 64'(0));
        chk("rst_flags", 64'({overflow, underflow}), 64'(0));
        rst = 1'b0;

        // Pop on empty: ignored, underflow set
        pop = 1'b1; step(); pop = 1'b0;
        chk("udf_set", 64'(underflow), 64'(1));
        chk("udf_pop_data", pop_data, 64'(0));
        chk("udf_count", 64'(count), 64'(0));

        // Single push latency
        push = 1'b1; push_data = 64'hA5; #1;
        chk("c0_ram_ena", 64'({ram_ena, ram_wra}), 64'(3));
        chk("c0_addra", 64'(ram_addra), 64'(0));
        @(posedge clk); #1; push = 1'b0;
        chk("c1_enb", 64'(ram_enb), 64'(1));
        chk("c1_addrb", 64'(ram_addrb), 64'(0));
        chk("c1_empty", 64'(empty), 64'(1));
        step();
        chk("c2_empty", 64'(empty), 64'(1));
        step();
        chk("c3_empty", 64'(empty), 64'(0));
        chk("c3_pop_data", pop_data, 64'hA5);
        chk("c3_count", 64'(count), 64'(1));
        pop = 1'b1; step(); pop = 1'b0;
        chk("after_pop_empty", 64'(empty), 64'(1));
        chk("after_pop_count", 64'(count), 64'(0));

        // Pop with one buffered word while the next read returns
        w0 = {$urandom, $urandom}; w1 = {$urandom, $urandom};
        push = 1'b1; push_data = w0; step();
        push_data = w1; step();
        push = 1'b0;
        chk("col_c2_empty", 64'(empty), 64'(1));
        step();
        chk("col_c3_head", pop_data, w0);
        pop = 1'b1; step(); pop = 1'b0;
        chk("col_new_head", pop_data, w1);
        chk("col_not_empty", 64'(empty), 64'(0));
        chk("col_count", 64'(count), 64'(1));
        pop = 1'b1; step(); pop = 1'b0;
        chk("col_drained", 64'(empty), 64'(1));

        // Fill to capacity, overflow, drain
        accepted = 0; guard = 0;
        while (accepted < DEPTH + 2 && guard < 50) begin
            push_data = {$urandom, $urandom};
            push = !full;
            if (push) accepted++;
            step(); guard++;
        end
        push = 1'b0;
        chk("fill_accepted", 64'(accepted), 64'(DEPTH + 2));
        repeat (3) step();
        chk("cap_full", 64'(full), 64'(1));
        chk("cap_count", 64'(count), 64'(DEPTH + 2));
        push = 1'b1; push_data = 64'hDEAD; step(); push = 1'b0;
        chk("ovf_set", 64'(overflow), 64'(1));
        chk("ovf_count", 64'(count), 64'(DEPTH + 2));
        for (int i = 0; i < DEPTH + 2; i++) begin
            pop = 1'b1;
            chk("drain_ready", 64'(empty), 64'(0));
            step();
        end
        pop = 1'b0;
        chk("drain_empty", 64'(empty), 64'(1));
        chk("drain_count", 64'(count), 64'(0));

        // Streaming: push and pop every cycle, no bubbles
        for (int i = 0; i < DEPTH; i++) begin
            push = 1'b1; push_data = 64'(i); step();
        end
        push = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 100; k++) begin
            push = 1'b1; push_data = 64'(DEPTH + k); pop = 1'b1;
            chk("stream_data", pop_data, 64'(k));
            chk("stream_valid", 64'(empty), 64'(0));
            chk("stream_count", 64'(count), 64'(DEPTH));
            step();
        end
        push = 1'b0; pop = 1'b0;
        guard = 0;
        while (model_q.size() > 0 && guard < 50) begin
            pop = !empty; step(); guard++;
        end
        pop = 1'b0;
        chk("stream_drained", 64'(count), 64'(0));

        // Asynchronous reset in the middle of traffic
        push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_data = {$urandom, $urandom}; step();
        end
        #1 rst = 1'b1;
        #1;
        chk("arst_empty", 64'(empty), 64'(1));
        chk("arst_full", 64'(full), 64'(0));
        chk("arst_count", 64'(count), 64'(0));
        chk("arst_ram_en", 64'({ram_ena, ram_wra, ram_enb}), 64'(0));
        chk("arst_flags", 64'({overflow, underflow}), 64'(0));
        @(posedge clk); #1;
        push = 1'b0; rst = 1'b0;

        // Random gaps, 23 words through a 5-entry RAM (pointer wrap)
        sent = 0; guard = 0;
        while ((sent < 23 || model_q.size() != 0) && guard < 2000) begin
            push      = (sent < 23) && ($urandom_range(0, 9) < 6);
            push_data = 64'h1000 + 64'(sent);
            if (push && !full) sent++;
            pop = ($urandom_range(0, 1) == 1);
            step(); guard++;
        end
        push = 1'b0; pop = 1'b0;
        chk("wrap_sent", 64'(sent), 64'(23));
        chk("wrap_pops", 64'(pop_total), 64'(23));
        chk("wrap_writes", 64'(wr_n), 64'(23));
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
